// File: rtl/mlp_pkg.sv
// Shared MLP datapath constants and the addend loader state type.
package mlp_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_LENGTH     = 42;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_e;

endpackage

// File: rtl/addend_loader.sv
// Addend loader: assembles a stream of signed samples into one parallel
// vector for the adder tree and holds it until the tree consumes it.
// Optional feature macro: ADDEND_LOADER_ZERO_PAD_EN (an early in_last pads the
// remaining lanes with zero instead of discarding the partial vector).
module addend_loader
    import mlp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned LENGTH     = DEFAULT_LENGTH
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic signed [DATA_WIDTH-1:0]  in_sample,
    input  logic                          in_valid,
    input  logic                          in_last,
    output logic                          out_ready,
    output logic signed [DATA_WIDTH-1:0]  out_vector [LENGTH],
    output logic                          out_valid,
    input  logic                          in_vector_ready,
    output logic [$clog2(LENGTH+1)-1:0]   out_count,
    output logic                          out_error
);

    localparam int unsigned COUNT_WIDTH = $clog2(LENGTH + 1);

`ifdef ADDEND_LOADER_ZERO_PAD_EN
    localparam bit ZERO_PAD = 1'b1;
`else
    localparam bit ZERO_PAD = 1'b0;
`endif

    loader_state_e state;
    loader_state_e state_nxt;
    logic          accept;
    logic          last_lane;
    logic          early_last;
    logic          error_nxt;

    // Next-state decode and framing-error detection.
    always_comb begin
        accept     = (state == FILL) && in_valid;
        last_lane  = (out_count == COUNT_WIDTH'(LENGTH - 1));
        early_last = accept && !last_lane && in_last;
        error_nxt  = accept && (last_lane ? !in_last : (in_last && !ZERO_PAD));
        state_nxt  = state;
        case (state)
            FILL: begin
                if (accept && (last_lane || (in_last && ZERO_PAD))) begin
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (in_vector_ready) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State register.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    // Handshake flags, error pulse and fill counter.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_ready <= 1'b1;
            out_valid <= 1'b0;
            out_error <= 1'b0;
            out_count <= '0;
        end else begin
            out_ready <= (state_nxt == FILL);
            out_valid <= (state_nxt == FULL);
            out_error <= error_nxt;
            if (state == FULL && in_vector_ready) begin
                out_count <= '0;
            end else if (accept) begin
                if (early_last && !ZERO_PAD) begin
                    out_count <= '0;
                end else begin
                    out_count <= out_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    // Lane storage: write the accepted sample, zero the tail on a padded early last.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                out_vector[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < LENGTH; i++) begin
                if (accept && out_count == COUNT_WIDTH'(i)) begin
                    out_vector[i] <= in_sample;
                end else if (early_last && ZERO_PAD && i > 32'(out_count)) begin
                    out_vector[i] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_addend_loader.sv
// Self-checking bench for addend_loader: a 4-lane instance driven by directed
// and random traffic against a queue-based vector model, plus a default
// 42-lane instance checked for lane contents and fill latency.
module tb_addend_loader;

`ifdef ADDEND_LOADER_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk;
    logic rst_n;

    // 4-lane instance
    logic signed [7:0] a_sample;
    logic              a_valid, a_last, a_vready;
    logic              a_ready, a_out_valid, a_error;
    logic signed [7:0] a_vec [4];
    logic [2:0]        a_count;

    // default 42-lane instance
    logic signed [7:0] b_sample;
    logic              b_valid, b_last, b_vready;
    logic              b_ready, b_out_valid, b_error;
    logic signed [7:0] b_vec [42];
    logic [5:0]        b_count;

    int n_vec;
    int n_bad;

    addend_loader #(.DATA_WIDTH(8), .LENGTH(4)) u_a (
        .in_clk(clk), .in_rst_n(rst_n), .in_sample(a_sample), .in_valid(a_valid),
        .in_last(a_last), .out_ready(a_ready), .out_vector(a_vec), .out_valid(a_out_valid),
        .in_vector_ready(a_vready), .out_count(a_count), .out_error(a_error)
    );

    addend_loader u_b (
        .in_clk(clk), .in_rst_n(rst_n), .in_sample(b_sample), .in_valid(b_valid),
        .in_last(b_last), .out_ready(b_ready), .out_vector(b_vec), .out_valid(b_out_valid),
        .in_vector_ready(b_vready), .out_count(b_count), .out_error(b_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: a vector is the list of accepted samples, closed by
    // the 4th sample or by in_last.
    bit m_full;
    int m_q[$];
    int m_vec[4];
    int m_cnt;
    bit m_err;

    task automatic model_reset();
        m_full = 1'b0;
        m_q.delete();
        m_cnt = 0;
        m_err = 1'b0;
        for (int i = 0; i < 4; i++) m_vec[i] = 0;
    endtask

    task automatic model_step(input bit v, input int s, input bit l, input bit vr);
        m_err = 1'b0;
        if (!m_full) begin
            if (v) begin
                m_q.push_back(s);
                if (m_q.size() == 4 || l) begin
                    if (m_q.size() == 4 || PAD) begin
                        m_err  = !l;
                        m_full = 1'b1;
                        m_cnt  = m_q.size();
                        for (int i = 0; i < 4; i++) m_vec[i] = (i < m_q.size()) ? m_q[i] : 0;
                    end else begin
                        m_err = 1'b1;
                    end
                    m_q.delete();
                end
            end
        end else if (vr) begin
            m_full = 1'b0;
        end
    endtask

    task automatic check_a(input string tag);
        check({tag, "_ready"}, int'(a_ready), int'(!m_full));
        check({tag, "_valid"}, int'(a_out_valid), int'(m_full));
        check({tag, "_error"}, int'(a_error), int'(m_err));
        check({tag, "_count"}, int'(a_count), m_full ? m_cnt : m_q.size());
        if (m_full) begin
            for (int i = 0; i < 4; i++) check({tag, "_lane"}, int'(a_vec[i]), m_vec[i]);
        end
    endtask

    task automatic cycle(input string tag, input bit v, input int s, input bit l, input bit vr);
        a_valid  = v;
        a_sample = 8'(s);
        a_last   = l;
        a_vready = vr;
        model_step(v, s, l, vr);
        @(posedge clk);
        #1;
        check_a(tag);
    endtask

    task automatic release_vector();
        cycle("release", 1'b0, 0, 1'b0, 1'b1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        a_valid = 1'b0; a_sample = '0; a_last = 1'b0; a_vready = 1'b0;
        b_valid = 1'b0; b_sample = '0; b_last = 1'b0; b_vready = 1'b0;
        model_reset();
        #12;
        check("rst_valid", int'(a_out_valid), 0);
        check("rst_count", int'(a_count), 0);
        check("rst_error", int'(a_error), 0);
        for (int i = 0; i < 4; i++) check("rst_lane", int'(a_vec[i]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back 1,-2,3,-4 with in_last on the 4th
        cycle("seq0", 1'b1, 1, 1'b0, 1'b0);
        cycle("seq1", 1'b1, -2, 1'b0, 1'b0);
        cycle("seq2", 1'b1, 3, 1'b0, 1'b0);
        cycle("seq3", 1'b1, -4, 1'b1, 1'b0);
        check("basic_valid", int'(a_out_valid), 1);
        check("basic_lane3", int'(a_vec[3]), -4);

        // Backpressure: in_valid held high while the vector is not consumed
        for (int i = 0; i < 10; i++) cycle("bp", 1'b1, 50 + i, 1'b0, 1'b0);
        release_vector();
        cycle("bp_l0", 1'b1, 9, 1'b0, 1'b0);
        cycle("bp_l1", 1'b1, 10, 1'b0, 1'b0);
        cycle("bp_l2", 1'b1, 11, 1'b0, 1'b0);
        cycle("bp_l3", 1'b1, 12, 1'b1, 1'b0);
        check("bp_lane0", int'(a_vec[0]), 9);
        release_vector();

        // Early last on the second sample
        cycle("early0", 1'b1, 5, 1'b0, 1'b0);
        cycle("early1", 1'b1, 6, 1'b1, 1'b0);
        check("early_error", int'(a_error), PAD ? 0 : 1);
        cycle("early_idle", 1'b0, 0, 1'b0, 1'b0);
        if (m_full) release_vector();

        // Missing last: error pulse, vector still delivered
        for (int i = 0; i < 4; i++) cycle("nolast", 1'b1, 20 + i, 1'b0, 1'b0);
        check("nolast_error", int'(a_error), 1);
        cycle("nolast_hold", 1'b0, 0, 1'b0, 1'b0);
        check("nolast_pulse", int'(a_error), 0);
        release_vector();

        // Asynchronous reset after two samples
        cycle("prerst0", 1'b1, 33, 1'b0, 1'b0);
        cycle("prerst1", 1'b1, 34, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("arst_valid", int'(a_out_valid), 0);
        check("arst_count", int'(a_count), 0);
        check("arst_error", int'(a_error), 0);
        for (int i = 0; i < 4; i++) check("arst_lane", int'(a_vec[i]), 0);
        model_reset();
        a_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) cycle("post_rst", 1'b1, 7, i == 3, 1'b0);
        for (int i = 0; i < 4; i++) check("sevens", int'(a_vec[i]), 7);
        release_vector();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            cycle("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128,
                  $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)));
        end

        // Default 42-lane instance: -128..-87, valid one cycle after lane 41
        for (int i = 0; i < 42; i++) begin
            b_valid  = 1'b1;
            b_sample = 8'(-128 + i);
            b_last   = (i == 41);
            @(posedge clk);
            #1;
            if (i < 41) check("l42_not_yet", int'(b_out_valid), 0);
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        check("l42_valid", int'(b_out_valid), 1);
        check("l42_count", int'(b_count), 42);
        check("l42_error", int'(b_error), 0);
        check("l42_ready", int'(b_ready), 0);
        for (int i = 0; i < 42; i++) check("l42_lane", int'(b_vec[i]), -128 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
